// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU / BCD display path:
// opcodes, display-select encodings and the controller state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam logic [1:0] SEL_RES = 2'b00;
  localparam logic [1:0] SEL_A   = 2'b01;
  localparam logic [1:0] SEL_B   = 2'b10;
  localparam logic [1:0] SEL_OP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle.
// load seeds the shift register and step counter; last is high while the
// step about to be taken is the final one.
module bin2bcd_seq #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  step,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [4*DIGITS-1:0]       r_bcd;
  logic [WIDTH-1:0]          r_bin;
  logic [CW-1:0]             r_cnt;
  logic [4*DIGITS-1:0]       w_adj;
  logic [4*DIGITS+WIDTH-1:0] w_next;

  // Add 3 to every digit that would reach 10 or more after doubling.
  function automatic logic [4*DIGITS-1:0] dabble_adjust(input logic [4*DIGITS-1:0] d);
    logic [4*DIGITS-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_adj  = dabble_adjust(r_bcd);
  assign w_next = {w_adj, r_bin} << 1;

  // Shift register and step counter; the binary MSB feeds digit 0 LSB.
  always_ff @(posedge clk) begin
    if (load) begin
      r_bcd <= '0;
      r_bin <= value;
      r_cnt <= CW'(WIDTH);
    end else if (step) begin
      r_bcd <= w_next[4*DIGITS+WIDTH-1:WIDTH];
      r_bin <= w_next[WIDTH-1:0];
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign bcd  = r_bcd;
  assign last = (r_cnt == CW'(1));

endmodule

// File: rtl/alu_bcd_seq.sv
// Sequential ALU with packed-BCD result display.
// start latches operands; one cycle executes the ALU, WIDTH cycles run the
// double-dabble converter, and a done pulse publishes y and the flags.
// Optional feature macro: MUL_EN (op 110 becomes an unsigned multiply;
// without it op 110 yields zero and no multiplier is built).
module alu_bcd_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [2:0]          op,
  input  logic                cin,
  input  logic [1:0]          select,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] y,
  output logic                carry_out,
  output logic                overflow
);

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [2:0]          r_op;
  logic                r_cin;
  logic [1:0]          r_sel;
  logic                r_carry;
  logic                r_ovf;
  logic [4*DIGITS-1:0] r_y;
  logic                r_carry_out;
  logic                r_ovf_out;
  logic                r_done;

  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_res;
  logic                w_c;
  logic                w_v;
  logic [WIDTH-1:0]    w_sel_val;
  logic [4*DIGITS-1:0] w_bcd;
  logic                w_last;
  logic                w_load;
  logic                w_step;
`ifdef MUL_EN
  logic [2*WIDTH-1:0]  w_prod;
`endif

  // ALU on the latched operands; flags describe the operation only.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
`ifdef MUL_EN
    w_prod = '0;
`endif
    case (r_op)
      OP_ADD: begin
        w_sum = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        // carry set means no borrow (a >= b)
        w_sum = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:   w_res = r_a & r_b;
      OP_OR:    w_res = r_a | r_b;
      OP_XOR:   w_res = r_a ^ r_b;
      OP_NOT:   w_res = ~r_a;
      OP_PASSB: w_res = r_b;
      OP_MUL: begin
`ifdef MUL_EN
        w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
        w_res  = w_prod[WIDTH-1:0];
        w_v    = |w_prod[2*WIDTH-1:WIDTH];
`else
        w_res  = '0;
`endif
      end
      default: w_res = '0;
    endcase
  end

  // Value routed to the converter according to the latched select.
  always_comb begin
    w_sel_val = '0;
    case (r_sel)
      SEL_RES: w_sel_val = w_res;
      SEL_A:   w_sel_val = r_a;
      SEL_B:   w_sel_val = r_b;
      default: w_sel_val = WIDTH'(r_op);
    endcase
  end

  assign w_load = (r_state == EXEC);
  assign w_step = (r_state == CONVERT);

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .load  (w_load),
    .value (w_sel_val),
    .step  (w_step),
    .bcd   (w_bcd),
    .last  (w_last)
  );

  // Operand latch on accepted start, internal flags captured in EXEC.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_a   <= a;
      r_b   <= b;
      r_op  <= op;
      r_cin <= cin;
      r_sel <= select;
    end
    if (r_state == EXEC) begin
      r_carry <= w_c;
      r_ovf   <= w_v;
    end
  end

  // Controller FSM with registered done pulse and displayed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_y         <= '0;
      r_carry_out <= 1'b0;
      r_ovf_out   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE:    if (start) r_state <= EXEC;
        EXEC:    r_state <= CONVERT;
        CONVERT: if (w_last) r_state <= DONE;
        DONE: begin
          r_y         <= w_bcd;
          r_carry_out <= r_carry;
          r_ovf_out   <= r_ovf;
          r_done      <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign y         = r_y;
  assign carry_out = r_carry_out;
  assign overflow  = r_ovf_out;

endmodule

// File: tb/tb_alu_bcd_seq.sv
// Directed bench for alu_bcd_seq: a WIDTH=4 and a WIDTH=8 instance,
// hand-computed BCD results, flags, latency, handshake and reset abort.
module tb_alu_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        s4, cin4;
  logic [3:0]  a4, b4;
  logic [2:0]  op4;
  logic [1:0]  sel4;
  logic        busy4, done4, c4, v4;
  logic [11:0] y4;

  logic        s8, cin8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [1:0]  sel8;
  logic        busy8, done8, c8, v8;
  logic [11:0] y8;

  int checks   = 0;
  int failures = 0;

  alu_bcd_seq #(.WIDTH(4), .DIGITS(3)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .op(op4), .cin(cin4),
    .select(sel4), .busy(busy4), .done(done4), .y(y4),
    .carry_out(c4), .overflow(v4)
  );

  alu_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .op(op8), .cin(cin8),
    .select(sel8), .busy(busy8), .done(done8), .y(y8),
    .carry_out(c8), .overflow(v8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation; glitch_at >= 0 re-pulses start with other operands
  // at that cycle index (edge count after the accepting edge).
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op, input logic c, input logic [1:0] sel,
                      input logic [11:0] ey, input logic ec, input logic ev,
                      input int glitch_at);
    int n;
    int act;
    bit busy_ok;
    @(negedge clk);
    a4 = a; b4 = b; op4 = op; cin4 = c; sel4 = sel; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0; a4 = ~a; b4 = ~b; op4 = ~op; cin4 = ~c; sel4 = ~sel;
    n = 0;
    busy_ok = 1'b1;
    while (!done4 && n < 40) begin
      if (!busy4) busy_ok = 1'b0;
      s4 = (n == glitch_at);
      @(negedge clk);
      n++;
    end
    s4 = 1'b0;
    check({tag, ".latency"}, n, 6);
    check({tag, ".busy_held"}, busy_ok, 1);
    check({tag, ".busy_at_done"}, busy4, 0);
    check({tag, ".y"}, y4, ey);
    check({tag, ".carry"}, c4, ec);
    check({tag, ".ovf"}, v4, ev);
    @(negedge clk);
    check({tag, ".done_pulse"}, done4, 0);
    check({tag, ".y_hold"}, y4, ey);
    act = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4 || busy4) act++;
      @(negedge clk);
    end
    check({tag, ".no_extra_op"}, act, 0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic c,
                      input logic [11:0] ey, input logic ec, input logic ev);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; op8 = op; cin8 = c; sel8 = 2'b00; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0; a8 = '0; b8 = '0;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, 10);
    check({tag, ".y"}, y8, ey);
    check({tag, ".carry"}, c8, ec);
    check({tag, ".ovf"}, v8, ev);
  endtask

  initial begin
    int n;
    int act;
    rst = 1'b1;
    s4 = 0; a4 = 0; b4 = 0; op4 = 0; cin4 = 0; sel4 = 0;
    s8 = 0; a8 = 0; b8 = 0; op8 = 0; cin8 = 0; sel8 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.y4", y4, 0);
    check("rst.flags4", {c4, v4}, 0);
    check("rst.done4", done4, 0);
    check("rst.busy4", busy4, 0);
    check("rst.y8", y8, 0);
    check("rst.busy8", busy8, 0);

    run4("add5_6",   4'd5, 4'd6, 3'b000, 1'b0, 2'b00, 12'h011, 1'b0, 1'b1, -1);
    run4("sub3_5",   4'd3, 4'd5, 3'b001, 1'b0, 2'b00, 12'h014, 1'b0, 1'b0, -1);
    run4("sub7_2",   4'd7, 4'd2, 3'b001, 1'b1, 2'b00, 12'h005, 1'b1, 1'b0, -1);
    run4("sub8_1",   4'd8, 4'd1, 3'b001, 1'b0, 2'b00, 12'h007, 1'b1, 1'b1, -1);
    run4("add7_8c",  4'd7, 4'd8, 3'b000, 1'b1, 2'b00, 12'h000, 1'b1, 1'b0, -1);
    run4("or8_3",    4'd8, 4'd3, 3'b011, 1'b0, 2'b00, 12'h011, 1'b0, 1'b0, -1);
    run4("not5",     4'd5, 4'd0, 3'b101, 1'b0, 2'b00, 12'h010, 1'b0, 1'b0, -1);
    run4("passb7",   4'd1, 4'd7, 3'b111, 1'b0, 2'b00, 12'h007, 1'b0, 1'b0, -1);
    run4("selA_add", 4'd9, 4'd9, 3'b000, 1'b0, 2'b01, 12'h009, 1'b1, 1'b1, -1);
    run4("selB_and", 4'd15, 4'd15, 3'b010, 1'b0, 2'b10, 12'h015, 1'b0, 1'b0, -1);
    run4("selOp_xor", 4'd3, 4'd6, 3'b100, 1'b0, 2'b11, 12'h004, 1'b0, 1'b0, -1);
    run4("busy_start", 4'd5, 4'd6, 3'b000, 1'b0, 2'b00, 12'h011, 1'b0, 1'b1, 2);
    run4("done_start", 4'd3, 4'd5, 3'b001, 1'b0, 2'b00, 12'h014, 1'b0, 1'b0, 5);
`ifdef MUL_EN
    run4("mul3_5",   4'd3, 4'd5, 3'b110, 1'b0, 2'b00, 12'h015, 1'b0, 1'b0, -1);
    run4("mul5_4",   4'd5, 4'd4, 3'b110, 1'b0, 2'b00, 12'h004, 1'b0, 1'b1, -1);
`else
    run4("op110",    4'd3, 4'd5, 3'b110, 1'b1, 2'b00, 12'h000, 1'b0, 1'b0, -1);
`endif

    run8("add200_55", 8'd200, 8'd55, 3'b000, 1'b0, 12'h255, 1'b0, 1'b0);
    run8("add200_56", 8'd200, 8'd56, 3'b000, 1'b0, 12'h000, 1'b1, 1'b0);

    // Abort an operation in CONVERT with reset, then start afresh.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd2; op4 = 3'b000; cin4 = 1'b0; sel4 = 2'b00; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    n = 0;
    while (n < 3) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", busy4, 0);
    check("abort.y", y4, 0);
    check("abort.flags", {c4, v4}, 0);
    check("abort.done", done4, 0);
    act = 0;
    for (int i = 0; i < 10; i++) begin
      if (done4 || busy4) act++;
      @(negedge clk);
    end
    check("abort.no_done", act, 0);
    run4("after_abort", 4'd7, 4'd2, 3'b000, 1'b0, 2'b00, 12'h009, 1'b0, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
